// File: rtl/tpu_ctrl_pkg.sv
// Shared types and helpers for the systolic array sequencer.
// State encoding plus schedule-length functions.
package tpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_RD_LAT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // last t in FEED is k_len + feed_tail
  function automatic int feed_tail(input int rows, input int cols);
    return max2(rows, cols) - 2;
  endfunction

  function automatic int drain_len(input int rd_lat, input int rows, input int cols);
    return rd_lat + rows + cols - 1;
  endfunction

  localparam int FEED_TAIL = feed_tail(DEF_ROWS, DEF_COLS);
  localparam int DRAIN_LEN = drain_len(DEF_RD_LAT, DEF_ROWS, DEF_COLS);

endpackage

// File: rtl/ctrl_skew_lane.sv
// One skewed read lane: enabled while LANE <= t < LANE + k_len.
// Compares are widened so LANE + k_len never overflows.
module ctrl_skew_lane #(
  parameter int LANE    = 0,
  parameter int K_WIDTH = 8
) (
  input  logic [K_WIDTH:0]   t,
  input  logic [K_WIDTH-1:0] k_len,
  output logic               rd_en
);

  localparam int W = K_WIDTH + 2;
  localparam logic [W-1:0] L = W'(LANE);

  logic [W-1:0] te;
  logic [W-1:0] ke;

  assign te    = W'(t);
  assign ke    = W'(k_len);
  assign rd_en = (te >= L) && (te < (L + ke));

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer: clear, skewed feed, drain, ofmap write, done.
// Optional PERF_CNT_EN adds a busy-cycle counter output.
module systolic_array_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int ARRAY_ROWS = 4,
  parameter int ARRAY_COLS = 4,
  parameter int K_WIDTH    = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = 1,
  localparam int CW        = clog2(ARRAY_COLS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [K_WIDTH-1:0]    k_len,
  output logic                  busy,
  output logic                  done,
  output logic                  array_clr_n,
  output logic [ARRAY_ROWS-1:0] ifmap_rd_en,
  output logic [ADDR_WIDTH-1:0] ifmap_rd_addr,
  output logic [ARRAY_COLS-1:0] w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  output logic                  ofmap_wr_en,
  output logic [CW-1:0]         ofmap_wr_col
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int TW = K_WIDTH + 1;
  localparam int NW = 16;
  localparam logic [TW-1:0] TAIL =
    TW'(feed_tail(ARRAY_ROWS, ARRAY_COLS));
  localparam logic [NW-1:0] DRAIN_LAST =
    NW'(drain_len(RD_LAT, ARRAY_ROWS, ARRAY_COLS) - 1);
  localparam logic [NW-1:0] WRITE_LAST = NW'(ARRAY_COLS - 1);

  state_t                  state, nxt_state;
  logic [TW-1:0]           t, nxt_t;
  logic [NW-1:0]           cnt, nxt_cnt;
  logic [K_WIDTH-1:0]      k_q;
  logic [ARRAY_ROWS-1:0]   row_en;
  logic [ARRAY_COLS-1:0]   col_en;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic                    accept;
  logic                    feed_last;
  logic                    nxt_feed;

  assign accept    = (state == IDLE) && start;
  assign feed_last = (t == ({1'b0, k_q} + TAIL));
  assign nxt_feed  = (nxt_state == FEED);
  assign nxt_addr  = ADDR_WIDTH'(nxt_t);

  for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_row
    ctrl_skew_lane #(.LANE(r), .K_WIDTH(K_WIDTH)) u_lane (
      .t     (nxt_t),
      .k_len (k_q),
      .rd_en (row_en[r])
    );
  end

  for (genvar c = 0; c < ARRAY_COLS; c++) begin : g_col
    ctrl_skew_lane #(.LANE(c), .K_WIDTH(K_WIDTH)) u_lane (
      .t     (nxt_t),
      .k_len (k_q),
      .rd_en (col_en[c])
    );
  end

  // next-state and schedule counters
  always_comb begin
    nxt_state = state;
    nxt_t     = t;
    nxt_cnt   = cnt;
    case (state)
      IDLE: begin
        if (start)
          nxt_state = (k_len != '0) ? CLEAR : DONE;
      end
      CLEAR: begin
        nxt_state = FEED;
        nxt_t     = '0;
      end
      FEED: begin
        if (feed_last) begin
          nxt_state = DRAIN;
          nxt_cnt   = '0;
        end else begin
          nxt_t = t + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          nxt_state = WRITE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      WRITE: begin
        if (cnt == WRITE_LAST)
          nxt_state = DONE;
        else
          nxt_cnt = cnt + 1'b1;
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // state, counters and outputs registered from next values
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      t             <= '0;
      cnt           <= '0;
      k_q           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      array_clr_n   <= 1'b0;
      ifmap_rd_en   <= '0;
      ifmap_rd_addr <= '0;
      w_rd_en       <= '0;
      w_rd_addr     <= '0;
      ofmap_wr_en   <= 1'b0;
      ofmap_wr_col  <= '0;
    end else begin
      state <= nxt_state;
      t     <= nxt_t;
      cnt   <= nxt_cnt;
      if (accept)
        k_q <= k_len;
      busy <= (nxt_state == CLEAR) || (nxt_state == FEED) ||
              (nxt_state == DRAIN) || (nxt_state == WRITE);
      done          <= (nxt_state == DONE);
      array_clr_n   <= (nxt_state != CLEAR);
      ifmap_rd_en   <= nxt_feed ? row_en : '0;
      w_rd_en       <= nxt_feed ? col_en : '0;
      ifmap_rd_addr <= nxt_feed ? nxt_addr : '0;
      w_rd_addr     <= nxt_feed ? nxt_addr : '0;
      ofmap_wr_en   <= (nxt_state == WRITE);
      ofmap_wr_col  <= (nxt_state == WRITE) ? CW'(nxt_cnt) : '0;
    end
  end

`ifdef PERF_CNT_EN
  // saturating count of busy cycles, cleared on accepted start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      perf_cycles <= '0;
    else if (accept)
      perf_cycles <= '0;
    else if (busy && (perf_cycles != '1))
      perf_cycles <= perf_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl (4x4, RD_LAT=1).
// Cycle n is observed at the n-th falling edge after start is driven.
module tb_systolic_array_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] k_len = 8'd0;
  logic       busy, done, array_clr_n;
  logic [3:0] ifmap_rd_en, w_rd_en;
  logic [7:0] ifmap_rd_addr, w_rd_addr;
  logic       ofmap_wr_en;
  logic [1:0] ofmap_wr_col;
`ifdef PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [29:0] V_RST  = 30'h0000_0000;
  localparam logic [29:0] V_IDLE = 30'h0800_0000;
  localparam logic [29:0] V_DONE = 30'h1800_0000;

  always #5 clk = ~clk;

  systolic_array_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .k_len         (k_len),
    .busy          (busy),
    .done          (done),
    .array_clr_n   (array_clr_n),
    .ifmap_rd_en   (ifmap_rd_en),
    .ifmap_rd_addr (ifmap_rd_addr),
    .w_rd_en       (w_rd_en),
    .w_rd_addr     (w_rd_addr),
    .ofmap_wr_en   (ofmap_wr_en),
    .ofmap_wr_col  (ofmap_wr_col)
`ifdef PERF_CNT_EN
    ,
    .perf_cycles   (perf_cycles)
`endif
  );

  function automatic logic [29:0] obs();
    return {busy, done, array_clr_n, ifmap_rd_en, w_rd_en,
            ifmap_rd_addr, w_rd_addr, ofmap_wr_en, ofmap_wr_col};
  endfunction

  // expected outputs in cycle c of a job with k>=1
  function automatic logic [29:0] expv(input int k, input int c);
    logic       b, d, cl, wr;
    logic [3:0] ie, we;
    logic [7:0] a;
    logic [1:0] col;
    int         t;
    bit         feed;
    feed = (c >= 2) && (c <= k + 4);
    t    = c - 2;
    b    = (c >= 1) && (c <= k + 16);
    d    = (c == k + 17);
    cl   = (c != 1);
    ie   = '0;
    we   = '0;
    a    = '0;
    if (feed) begin
      a = 8'(t % 256);
      for (int r = 0; r < 4; r++) begin
        ie[r] = (t >= r) && (t < r + k);
        we[r] = (t >= r) && (t < r + k);
      end
    end
    wr  = (c >= k + 13) && (c <= k + 16);
    col = wr ? 2'(c - k - 13) : 2'd0;
    return {b, d, cl, ie, we, a, a, wr, col};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (obs() !== V_RST) begin
      errors++;
      $display("FAIL reset got %h want %h", obs(), V_RST);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL idle got %h want %h", obs(), V_IDLE);
    end
  endtask

  task automatic test_basic();
    k_len = 8'd3;
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (obs() !== expv(3, c)) begin
        errors++;
        $display("FAIL basic c=%0d got %h want %h", c, obs(), expv(3, c));
      end
    end
  endtask

  task automatic test_zero();
    k_len = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (obs() !== V_DONE) begin
      errors++;
      $display("FAIL zero_done got %h want %h", obs(), V_DONE);
    end
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== V_IDLE) begin
        errors++;
        $display("FAIL zero_idle c=%0d got %h want %h", c, obs(), V_IDLE);
      end
    end
  endtask

  task automatic test_start_held();
    logic [29:0] e;
    k_len = 8'd3;
    start = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      if (c == 22) start = 1'b0;
      e = (c <= 21) ? expv(3, c) : expv(3, c - 21);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL held c=%0d got %h want %h", c, obs(), e);
      end
    end
  endtask

  task automatic test_async_reset();
    k_len = 8'd3;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (obs() !== expv(3, c)) begin
        errors++;
        $display("FAIL pre_rst c=%0d got %h want %h", c, obs(), expv(3, c));
      end
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (obs() !== V_RST) begin
      errors++;
      $display("FAIL async_rst got %h want %h", obs(), V_RST);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL post_rst got %h want %h", obs(), V_IDLE);
    end
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (obs() !== expv(3, c)) begin
        errors++;
        $display("FAIL rerun c=%0d got %h want %h", c, obs(), expv(3, c));
      end
    end
  endtask

  task automatic test_wrap();
    int ci[4];
    int cw[4];
    for (int r = 0; r < 4; r++) begin
      ci[r] = 0;
      cw[r] = 0;
    end
    k_len = 8'd255;
    start = 1'b1;
    for (int c = 1; c <= 273; c++) begin
      @(negedge clk);
      start = 1'b0;
      for (int r = 0; r < 4; r++) begin
        if (ifmap_rd_en[r]) ci[r]++;
        if (w_rd_en[r]) cw[r]++;
      end
      checks++;
      if (obs() !== expv(255, c)) begin
        errors++;
        $display("FAIL wrap c=%0d got %h want %h", c, obs(), expv(255, c));
      end
      if (c == 258) begin
        checks++;
        if (ifmap_rd_addr !== 8'd0 || ifmap_rd_en[3] !== 1'b1) begin
          errors++;
          $display("FAIL wrap_t256 got %h/%b want 00/1", ifmap_rd_addr, ifmap_rd_en[3]);
        end
      end
      if (c == 259) begin
        checks++;
        if (ifmap_rd_addr !== 8'd1 || w_rd_addr !== 8'd1) begin
          errors++;
          $display("FAIL wrap_t257 got %h %h want 01 01", ifmap_rd_addr, w_rd_addr);
        end
      end
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (ci[r] != 255) begin
        errors++;
        $display("FAIL row_len r=%0d got %0d want 255", r, ci[r]);
      end
      checks++;
      if (cw[r] != 255) begin
        errors++;
        $display("FAIL col_len c=%0d got %0d want 255", r, cw[r]);
      end
    end
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    k_len = 8'd3;
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1 || c == 2) begin
        checks++;
        if (perf_cycles !== 32'(c - 1)) begin
          errors++;
          $display("FAIL perf_c%0d got %0d want %0d", c, perf_cycles, c - 1);
        end
      end
    end
    checks++;
    if (perf_cycles !== 32'd19) begin
      errors++;
      $display("FAIL perf_end got %0d want 19", perf_cycles);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (perf_cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_clr got %0d want 0", perf_cycles);
    end
    for (int c = 2; c <= 21; c++) @(negedge clk);
    checks++;
    if (perf_cycles !== 32'd19) begin
      errors++;
      $display("FAIL perf_hold got %0d want 19", perf_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_start_held();
    test_async_reset();
    test_wrap();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
